// File: rtl/time_set_rx_if.sv
// Time-set bus: serial line in, validated BCD time and strobes out.
interface time_set_rx_if;
  logic       rxd;
  logic       load;
  logic [2:0] min10;
  logic [3:0] min1;
  logic [2:0] sec10;
  logic [3:0] sec1;
  logic       err;

  modport master (input rxd, output load, min10, min1, sec10, sec1, err);
  modport slave  (output rxd, input load, min10, min1, sec10, sec1, err);
endinterface

// File: rtl/time_set_rx.sv
// Serial time-set receiver: UART 8N1 front end plus an "MM:SS<CR>" parser
// that presents validated BCD digits with one-cycle load/err strobes.
module time_set_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input logic          clk,
  input logic          rst_n,
  time_set_rx_if.master bus
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rx_state_t;
  typedef enum logic [2:0] {P_M10, P_M1, P_COL, P_S10, P_S1, P_CR} p_state_t;

  logic       sync1, rxs, rxs_d;
  rx_state_t  rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       byte_stb, frame_err;

  p_state_t   p_state;
  logic [2:0] sh_m10, sh_s10;
  logic [3:0] sh_m1, sh_s1;
  logic       syn_err, cr_ok;
  logic       is_d05, is_d09;

  // rxs_d lets IDLE react only to a true falling edge, never to a line still low after a break
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= bus.rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        IDLE: if (rxs_d && !rxs) begin
          rx_state <= START;
          baud_cnt <= HALF;
        end
        START: if (baud_cnt != '0) baud_cnt <= baud_cnt - ONE;
          else if (rxs) rx_state <= IDLE;
          else begin
            rx_state <= DATA;
            baud_cnt <= FULL;
            bit_cnt  <= '0;
          end
        DATA: if (baud_cnt != '0) baud_cnt <= baud_cnt - ONE;
          else begin
            shreg    <= {rxs, shreg[7:1]};
            baud_cnt <= FULL;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= STOP;
          end
        STOP: if (baud_cnt != '0) baud_cnt <= baud_cnt - ONE;
          else if (rxs) begin
            byte_stb <= 1'b1;
            rx_state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            rx_state  <= WAITHI;
          end
        WAITHI: if (rxs) rx_state <= IDLE;
        default: rx_state <= IDLE;
      endcase
    end
  end

  assign is_d05 = (shreg >= 8'h30) && (shreg <= 8'h35);
  assign is_d09 = (shreg >= 8'h30) && (shreg <= 8'h39);

  // Decisions are registered in syn_err/cr_ok so each strobe fires one cycle after the byte is judged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_M10;
      sh_m10    <= '0;
      sh_m1     <= '0;
      sh_s10    <= '0;
      sh_s1     <= '0;
      syn_err   <= 1'b0;
      cr_ok     <= 1'b0;
      bus.load  <= 1'b0;
      bus.err   <= 1'b0;
      bus.min10 <= '0;
      bus.min1  <= '0;
      bus.sec10 <= '0;
      bus.sec1  <= '0;
    end else begin
      bus.load <= cr_ok;
      bus.err  <= syn_err;
      syn_err  <= 1'b0;
      cr_ok    <= 1'b0;
      if (cr_ok) begin
        bus.min10 <= sh_m10;
        bus.min1  <= sh_m1;
        bus.sec10 <= sh_s10;
        bus.sec1  <= sh_s1;
      end
      if (frame_err) begin
        p_state <= P_M10;
        syn_err <= 1'b1;
        sh_m10  <= '0;
        sh_m1   <= '0;
        sh_s10  <= '0;
        sh_s1   <= '0;
      end else if (byte_stb) begin
        if (p_state == P_M10 && shreg == 8'h0A) begin
          p_state <= P_M10;
        end else if (p_state == P_M10 && is_d05) begin
          sh_m10  <= shreg[2:0];
          p_state <= P_M1;
        end else if (p_state == P_M1 && is_d09) begin
          sh_m1   <= shreg[3:0];
          p_state <= P_COL;
        end else if (p_state == P_COL && shreg == 8'h3A) begin
          p_state <= P_S10;
        end else if (p_state == P_S10 && is_d05) begin
          sh_s10  <= shreg[2:0];
          p_state <= P_S1;
        end else if (p_state == P_S1 && is_d09) begin
          sh_s1   <= shreg[3:0];
          p_state <= P_CR;
        end else if (p_state == P_CR && shreg == 8'h0D) begin
          cr_ok   <= 1'b1;
          p_state <= P_M10;
        end else begin
          syn_err <= 1'b1;
          p_state <= P_M10;
          sh_m10  <= '0;
          sh_m1   <= '0;
          sh_s10  <= '0;
          sh_s1   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_set_rx.sv
// Directed bench for time_set_rx: sends UART frames and checks strobes and digits.
`timescale 1ns/1ps
module tb_time_set_rx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  time_set_rx_if bus();

  time_set_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #500 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, stop_cyc = 0, last_load_cyc = 0;
  int load_cnt = 0, err_cnt = 0, overlap_cnt = 0, long_cnt = 0, hold_viol = 0;
  int l0, e0, n0;
  logic [13:0] load_vals[$];
  logic [13:0] cur_time, prev_time;
  logic load_q = 1'b0, err_q = 1'b0;

  assign cur_time = {bus.min10, bus.min1, bus.sec10, bus.sec1};

  function automatic logic [13:0] pack_time(int m10, int m1, int s10, int s1);
    return {3'(m10), 4'(m1), 3'(s10), 4'(s1)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts pulses, records loaded values, flags overlap, stretch and drift
  always @(negedge clk) begin
    if (bus.load) begin
      load_cnt++;
      last_load_cyc = cyc;
      load_vals.push_back(cur_time);
    end
    if (bus.err) err_cnt++;
    if (bus.load && bus.err) overlap_cnt++;
    if ((bus.load && load_q) || (bus.err && err_q)) long_cnt++;
    if (rst_n && !bus.load && cur_time !== prev_time) hold_viol++;
    load_q = bus.load;
    err_q = bus.err;
    prev_time = cur_time;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    bus.rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = data[i];
      repeat (DIV) @(negedge clk);
    end
    stop_cyc = cyc;
    bus.rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    bus.rxd = 1'b1;
  endtask

  task automatic sendText(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.rxd = 1'b1;
    rst_n = 1'b0;
    idle(3);
    checkOutput("reset_load", bus.load, 0);
    checkOutput("reset_err", bus.err, 0);
    checkOutput("reset_time", cur_time, 0);
    rst_n = 1'b1;
    idle(5);

    $display("[TB] valid command 12:34");
    l0 = load_cnt; e0 = err_cnt;
    sendText("12:34\r");
    idle(20);
    checkOutput("t1_loads", load_cnt - l0, 1);
    checkOutput("t1_errs", err_cnt - e0, 0);
    checkOutput("t1_time", cur_time, pack_time(1, 2, 3, 4));
    checkOutput("t1_latency", last_load_cyc - stop_cyc, 11);

    $display("[TB] out-of-range tens digit, then 05:09");
    l0 = load_cnt; e0 = err_cnt;
    applyStimulus("6", 1'b1);
    idle(5);
    checkOutput("t2_err_at_6", err_cnt - e0, 1);
    sendText("1:00\r");
    idle(20);
    checkOutput("t2_errs", err_cnt - e0, 3);
    checkOutput("t2_loads", load_cnt - l0, 0);
    checkOutput("t2_hold", cur_time, pack_time(1, 2, 3, 4));
    l0 = load_cnt; e0 = err_cnt;
    sendText("05:09\r");
    idle(20);
    checkOutput("t2b_loads", load_cnt - l0, 1);
    checkOutput("t2b_errs", err_cnt - e0, 0);
    checkOutput("t2b_time", cur_time, pack_time(0, 5, 0, 9));

    $display("[TB] framing error mid-command");
    l0 = load_cnt; e0 = err_cnt;
    applyStimulus("1", 1'b1);
    applyStimulus(8'h33, 1'b0);
    idle(5);
    checkOutput("t3_frame_err", err_cnt - e0, 1);
    idle(5);
    sendText("2:00\r");
    idle(20);
    checkOutput("t3_errs", err_cnt - e0, 3);
    checkOutput("t3_loads", load_cnt - l0, 0);
    checkOutput("t3_hold", cur_time, pack_time(0, 5, 0, 9));

    $display("[TB] short glitch on the line");
    l0 = load_cnt; e0 = err_cnt;
    bus.rxd = 1'b0;
    idle(3);
    bus.rxd = 1'b1;
    idle(30);
    checkOutput("t4_loads", load_cnt - l0, 0);
    checkOutput("t4_errs", err_cnt - e0, 0);

    $display("[TB] reset during a frame, then 59:59");
    bus.rxd = 1'b0;
    idle(DIV);
    bus.rxd = 1'b1;
    idle(DIV);
    bus.rxd = 1'b0;
    idle(5);
    rst_n = 1'b0;
    idle(2);
    checkOutput("t5_rst_time", cur_time, 0);
    checkOutput("t5_rst_load", bus.load, 0);
    checkOutput("t5_rst_err", bus.err, 0);
    bus.rxd = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    l0 = load_cnt; e0 = err_cnt;
    sendText("59:59\r");
    idle(20);
    checkOutput("t5_loads", load_cnt - l0, 1);
    checkOutput("t5_errs", err_cnt - e0, 0);
    checkOutput("t5_time", cur_time, pack_time(5, 9, 5, 9));

    $display("[TB] back-to-back commands with CRLF");
    l0 = load_cnt; e0 = err_cnt; n0 = load_vals.size();
    sendText("00:00\r\n12:00\r");
    idle(20);
    checkOutput("t6_loads", load_cnt - l0, 2);
    checkOutput("t6_errs", err_cnt - e0, 0);
    checkOutput("t6_first", (load_vals.size() > n0) ? int'(load_vals[n0]) : -1,
                pack_time(0, 0, 0, 0));
    checkOutput("t6_second", (load_vals.size() > n0 + 1) ? int'(load_vals[n0 + 1]) : -1,
                pack_time(1, 2, 0, 0));

    checkOutput("overlap", overlap_cnt, 0);
    checkOutput("pulse_width", long_cnt, 0);
    checkOutput("hold_drift", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
